// File: rtl/qsort_range_sched_if.sv
// Partition job handshake between the range scheduler and the partition unit.
// The scheduler issues (lo,hi) jobs; the partition unit answers with the pivot.
interface qsort_range_sched_if #(
    parameter int IDX_W = 3
);
    logic             part_start;
    logic [IDX_W-1:0] part_lo;
    logic [IDX_W-1:0] part_hi;
    logic             part_done;
    logic [IDX_W-1:0] part_pivot;

    modport master (
        output part_start, part_lo, part_hi,
        input  part_done, part_pivot
    );

    modport slave (
        input  part_start, part_lo, part_hi,
        output part_done, part_pivot
    );
endinterface

// File: rtl/qsort_range_sched.sv
// Quicksort range scheduler: LIFO of (lo,hi) ranges, one partition job at a
// time, qcomp once no range of two or more elements is left.
module qsort_range_sched #(
    parameter int N           = 8,
    parameter int IDX_W       = 3,
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    qsort_range_sched_if.master pif,
    output logic        busy,
    output logic        qcomp,
    output logic        err,
    output logic        stack_ovf,
    output logic [15:0] job_cnt
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [IDX_W-1:0] HI0  = IDX_W'(N - 1);
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE, POP, ISSUE, WAIT, PUSH_R, PUSH_L, DONE, ERR
    } state_t;

    typedef logic [IDX_W:0] ext_t;

    state_t             state, state_n;
    logic [SP_W-1:0]    sp, sp_n;
    logic [2*IDX_W-1:0] stk [2**AW];
    logic [IDX_W-1:0]   lo, hi, piv;

    logic               push, pop, cap, clr, ovf_set, cnt_inc;
    logic [2*IDX_W-1:0] push_val;
    logic [AW-1:0]      wr_idx, top_idx;
    logic               full;
    ext_t               lo_e, hi_e, p_e, pin_e;

    // Index compares run one bit wider so hi=N-1 plus one cannot wrap.
    assign lo_e    = {1'b0, lo};
    assign hi_e    = {1'b0, hi};
    assign p_e     = {1'b0, piv};
    assign pin_e   = {1'b0, pif.part_pivot};
    assign full    = (sp == SP_FULL);
    assign top_idx = AW'(sp - 1'b1);

    always_comb begin
        state_n  = state;
        sp_n     = sp;
        push     = 1'b0;
        push_val = '0;
        pop      = 1'b0;
        cap      = 1'b0;
        clr      = 1'b0;
        ovf_set  = 1'b0;
        cnt_inc  = 1'b0;
        wr_idx   = AW'(sp);
        unique case (state)
            IDLE, DONE, ERR: begin
                if (init) begin
                    clr  = 1'b1;
                    sp_n = '0;
                    if (N < 2) begin
                        state_n = DONE;
                    end else begin
                        push     = 1'b1;
                        push_val = {{IDX_W{1'b0}}, HI0};
                        wr_idx   = '0;
                        sp_n     = SP_W'(1);
                        state_n  = POP;
                    end
                end
            end
            POP: begin
                if (sp == '0) begin
                    state_n = DONE;
                end else begin
                    pop     = 1'b1;
                    sp_n    = sp - 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_inc = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (pif.part_done) begin
                    cap = 1'b1;
                    if (pin_e < lo_e || pin_e > hi_e)
                        state_n = ERR;
                    else
                        state_n = PUSH_R;
                end
            end
            PUSH_R: begin
                state_n = PUSH_L;
                if (p_e + ext_t'(1) < hi_e) begin
                    if (full) begin
                        ovf_set = 1'b1;
                        state_n = ERR;
                    end else begin
                        push     = 1'b1;
                        push_val = {IDX_W'(p_e + ext_t'(1)), hi};
                        sp_n     = sp + 1'b1;
                    end
                end
            end
            PUSH_L: begin
                state_n = POP;
                // Written as p > lo+1 so that p=0 never underflows.
                if (p_e > lo_e + ext_t'(1)) begin
                    if (full) begin
                        ovf_set = 1'b1;
                        state_n = ERR;
                    end else begin
                        push     = 1'b1;
                        push_val = {lo, IDX_W'(p_e - ext_t'(1))};
                        sp_n     = sp + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sp        <= '0;
            lo        <= '0;
            hi        <= '0;
            piv       <= '0;
            stack_ovf <= 1'b0;
            job_cnt   <= '0;
        end else begin
            state <= state_n;
            sp    <= sp_n;
            if (pop)
                {lo, hi} <= stk[top_idx];
            if (cap)
                piv <= pif.part_pivot;
            if (clr) begin
                stack_ovf <= 1'b0;
                job_cnt   <= '0;
            end
            if (ovf_set)
                stack_ovf <= 1'b1;
            if (cnt_inc && job_cnt != 16'hffff)
                job_cnt <= job_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stk[wr_idx] <= push_val;
    end

    assign busy           = !(state inside {IDLE, DONE, ERR});
    assign qcomp          = (state == DONE);
    assign err            = (state == ERR);
    assign pif.part_start = (state == ISSUE);
    assign pif.part_lo    = lo;
    assign pif.part_hi    = hi;
endmodule

// File: tb/tb_qsort_range_sched.sv
// Directed bench for qsort_range_sched: three builds (N=8 deep stack,
// N=8 one-entry stack, N=1) driven from a single linear sequence.
module tb_qsort_range_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_a = 1'b0, init_b = 1'b0, init_c = 1'b0;
    logic busy_a, qcomp_a, err_a, ovf_a;
    logic busy_b, qcomp_b, err_b, ovf_b;
    logic busy_c, qcomp_c, err_c, ovf_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int total = 0;
    int fails = 0;
    logic [5:0] jobs[$];

    always #5 clk = ~clk;

    qsort_range_sched_if #(.IDX_W(3)) ia ();
    qsort_range_sched_if #(.IDX_W(3)) ib ();
    qsort_range_sched_if #(.IDX_W(1)) ic ();

    qsort_range_sched #(.N(8), .IDX_W(3), .STACK_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .init(init_a), .pif(ia),
        .busy(busy_a), .qcomp(qcomp_a), .err(err_a),
        .stack_ovf(ovf_a), .job_cnt(cnt_a)
    );
    qsort_range_sched #(.N(8), .IDX_W(3), .STACK_DEPTH(1)) dut_b (
        .clk(clk), .rst(rst), .init(init_b), .pif(ib),
        .busy(busy_b), .qcomp(qcomp_b), .err(err_b),
        .stack_ovf(ovf_b), .job_cnt(cnt_b)
    );
    qsort_range_sched #(.N(1), .IDX_W(1), .STACK_DEPTH(8)) dut_c (
        .clk(clk), .rst(rst), .init(init_c), .pif(ic),
        .busy(busy_c), .qcomp(qcomp_c), .err(err_c),
        .stack_ovf(ovf_c), .job_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_a();
        init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
    endtask

    task automatic wait_a(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ia.part_start) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // mode 0: pivot=lo, 1: midpoint, 2: pivot=lo then an out-of-range 0
    task automatic finish_a(input int mode);
        int lo, hi, p;
        for (int c = 0; c < 300; c++) begin
            if (qcomp_a || err_a) break;
            if (ia.part_start) begin
                lo = int'(ia.part_lo);
                hi = int'(ia.part_hi);
                jobs.push_back({ia.part_lo, ia.part_hi});
                p = (mode == 1) ? (lo + hi) / 2 : lo;
                if (mode == 2 && jobs.size() == 2) p = 0;
                @(negedge clk);
                ia.part_done  = 1'b1;
                ia.part_pivot = 3'(p);
                @(negedge clk);
                ia.part_done  = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        bit ok;
        int lat;
        logic [5:0] gold_mid [4];
        gold_mid[0] = {3'd0, 3'd7};
        gold_mid[1] = {3'd0, 3'd2};
        gold_mid[2] = {3'd4, 3'd7};
        gold_mid[3] = {3'd6, 3'd7};
        ia.part_done = 1'b0; ia.part_pivot = '0;
        ib.part_done = 1'b0; ib.part_pivot = '0;
        ic.part_done = 1'b0; ic.part_pivot = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_qcomp", qcomp_a, 0);
        check("rst_err", err_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_start", ia.part_start, 0);
        check("rst_b_ovf", ovf_b, 0);
        check("rst_c_qcomp", qcomp_c, 0);
        rst = 1'b0;
        @(negedge clk);

        // reset while waiting on a job, then a stray part_done
        pulse_a();
        wait_a(ok);
        check("first_start", ok, 1);
        @(negedge clk);
        check("in_wait_busy", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ia.part_done = 1'b1;
        ia.part_pivot = 3'd3;
        @(negedge clk);
        ia.part_done = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_cnt", cnt_a, 0);
        check("abort_lohi", {ia.part_lo, ia.part_hi}, 0);
        @(negedge clk);
        check("abort_start", ia.part_start, 0);
        check("abort_qcomp", qcomp_a, 0);

        // init latency, then a midpoint-pivot sort
        init_a = 1'b1;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            init_a = 1'b0;
            lat++;
            if (ia.part_start) break;
        end
        check("init_latency", lat, 2);
        check("first_job", {ia.part_lo, ia.part_hi}, {3'd0, 3'd7});
        jobs.delete();
        finish_a(1);
        check("mid_njobs", jobs.size(), 4);
        for (int i = 0; i < 4 && i < jobs.size(); i++)
            check($sformatf("mid_job%0d", i), jobs[i], gold_mid[i]);
        check("mid_qcomp", qcomp_a, 1);
        check("mid_cnt", cnt_a, 4);
        check("mid_err", err_a, 0);
        @(negedge clk);
        check("done_hold", qcomp_a, 1);

        // pivot=lo sort with ignored part_done in ISSUE and init in WAIT
        pulse_a();
        check("reinit_qcomp", qcomp_a, 0);
        check("reinit_cnt", cnt_a, 0);
        wait_a(ok);
        check("lo_start", ok, 1);
        ia.part_done = 1'b1;
        ia.part_pivot = 3'd3;
        @(negedge clk);
        ia.part_done = 1'b0;
        init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        check("wait_busy", busy_a, 1);
        check("wait_start", ia.part_start, 0);
        check("wait_cnt", cnt_a, 1);
        ia.part_done = 1'b1;
        ia.part_pivot = 3'd0;
        @(negedge clk);
        ia.part_done = 1'b0;
        jobs.delete();
        jobs.push_back({3'd0, 3'd7});
        finish_a(0);
        check("lo_njobs", jobs.size(), 7);
        for (int i = 1; i < 7 && i < jobs.size(); i++)
            check($sformatf("lo_job%0d", i), jobs[i], {3'(i), 3'd7});
        check("lo_qcomp", qcomp_a, 1);
        check("lo_cnt", cnt_a, 7);

        // out-of-range pivot on the second job
        pulse_a();
        jobs.delete();
        finish_a(2);
        check("bad_err", err_a, 1);
        check("bad_ovf", ovf_a, 0);
        check("bad_qcomp", qcomp_a, 0);
        check("bad_busy", busy_a, 0);
        check("bad_cnt", cnt_a, 2);
        pulse_a();
        check("err_clr", err_a, 0);
        check("err_restart", busy_a, 1);

        // one-entry stack overflows on the left push of the first job
        init_b = 1'b1;
        @(negedge clk);
        init_b = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ib.part_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b_start", ok, 1);
        @(negedge clk);
        ib.part_done = 1'b1;
        ib.part_pivot = 3'd3;
        @(negedge clk);
        ib.part_done = 1'b0;
        repeat (3) @(negedge clk);
        check("b_err", err_b, 1);
        check("b_ovf", ovf_b, 1);
        check("b_qcomp", qcomp_b, 0);
        check("b_busy", busy_b, 0);
        check("b_cnt", cnt_b, 1);

        // N=1 build completes on the cycle after init
        init_c = 1'b1;
        @(negedge clk);
        init_c = 1'b0;
        check("c_qcomp", qcomp_c, 1);
        check("c_cnt", cnt_c, 0);
        check("c_busy", busy_c, 0);
        check("c_start", ic.part_start, 0);
        check("c_err", err_c, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
